mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_align.sv | 69 ++++++
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM pipeline stage and its alignment helper.
package mem_pkg;

  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned DEPTH_DEF       = 32;
  localparam int unsigned REG_W_DEF       = 5;
  localparam int unsigned WAIT_CYCLES_DEF = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // The unused encoding 2'b11 behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    size_e sz;
    case (raw)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the MEM stage: lane enables, store replication,
// load extraction with extension, and the alignment check.
module mem_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              access_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [3:0]        lane_en_o,
  output logic [DATA_W-1:0] wdata_rep_o,
  output logic [DATA_W-1:0] load_o,
  output logic              misalign_o
);

  size_e       size;
  logic        bad_align;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign size = decode_size(size_i);

  always_comb begin
    bad_align = 1'b0;
    case (size)
      SZ_HALF: bad_align = addr_lo_i[0];
      SZ_WORD: bad_align = |addr_lo_i;
      default: bad_align = 1'b0;
    endcase
  end

  assign misalign_o = access_i & bad_align;

  // Lane enables and replicated store data; the merge keeps only enabled lanes.
  always_comb begin
    lane_en_o   = 4'b1111;
    wdata_rep_o = wdata_i;
    case (size)
      SZ_BYTE: begin
        lane_en_o   = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_en_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      default: begin
        lane_en_o   = 4'b1111;
        wdata_rep_o = wdata_i;
      end
    endcase
  end

  always_comb begin
    load_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
    load_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    load_o    = rword_i;
    case (size)
      SZ_BYTE: load_o = unsigned_i ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
      SZ_HALF: load_o = unsigned_i ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-organised data RAM with sub-word access,
// optional wait-state insertion, and the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_in,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [DATA_W-1:0] address_mem,
  input  logic [DATA_W-1:0] write_data_mem,
  input  logic [REG_W-1:0]  write_register_ex,
  output logic [1:0]        wb,
  output logic [REG_W-1:0]  write_register_mem,
  output logic [DATA_W-1:0] address_wb,
  output logic [DATA_W-1:0] read_data,
  output logic              misalign,
  output logic              stall,
  output logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] ram_adr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;
  logic [3:0]        lane_en;
  logic              access;
  logic              mis;
  logic              commit;
  logic              store_commit;
  logic              ram_we;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        wb_q, wb_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [DATA_W-1:0] ram_adr_q, ram_adr_d;

  // Upper address bits are ignored so out-of-range addresses wrap.
  assign idx    = address_mem[IDX_W+1:2];
  assign rword  = ram_q[idx];
  assign access = m_read | m_write;

  mem_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .access_i    (access),
    .size_i      (m_size),
    .unsigned_i  (m_unsigned),
    .addr_lo_i   (address_mem[1:0]),
    .wdata_i     (write_data_mem),
    .rword_i     (rword),
    .lane_en_o   (lane_en),
    .wdata_rep_o (wdata_rep),
    .load_o      (load_val),
    .misalign_o  (mis)
  );

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{lane_en[i]}};
    end
  end

  assign merged = (rword & ~lane_mask) | (wdata_rep & lane_mask);

  // Wait-state sequencer: N stall cycles, then one commit cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (WAIT_CYCLES != 0)) begin
          stall   = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = WAIT;
        end else begin
          commit = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign store_commit = commit & m_write & ~mis;
  assign ram_we       = store_commit & ~rst;

  // Pipeline capture on commit; a stall cycle launches a bubble.
  always_comb begin
    wb_d       = wb_q;
    wreg_d     = wreg_q;
    adr_d      = adr_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    ram_data_d = ram_data_q;
    ram_adr_d  = ram_adr_q;
    if (commit) begin
      wb_d    = wb_in;
      wreg_d  = write_register_ex;
      adr_d   = address_mem;
      rdata_d = (m_read && !mis) ? load_val : '0;
      mis_d   = mis;
      if (store_commit) begin
        ram_data_d = merged;
        ram_adr_d  = address_mem;
      end
    end else begin
      wb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      wreg_q     <= '0;
      adr_q      <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      ram_data_q <= '0;
      ram_adr_q  <= '0;
    end else begin
      wb_q       <= wb_d;
      wreg_q     <= wreg_d;
      adr_q      <= adr_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
      ram_data_q <= ram_data_d;
      ram_adr_q  <= ram_adr_d;
    end
  end

  // RAM contents survive reset; only the write is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[idx] <= merged;
    end
  end

  assign wb                 = wb_q;
  assign write_register_mem = wreg_q;
  assign address_wb         = adr_q;
  assign read_data          = rdata_q;
  assign misalign           = mis_q;
  assign ram_data           = ram_data_q;
  assign ram_adr            = ram_adr_q;

endmodule
